// File: rtl/lock_ctrl.sv
// Keypad password-entry controller: buffers BCD digits, checks them on enter, and runs LOCKED/OPEN/ERROR with timed relock.
// Latency: every output changes one clock after the key event or timer terminal count that causes it.
// Backpressure: none. Each key_valid pulse is consumed in its cycle; keys that arrive in OPEN/ERROR (other than enter in OPEN) are dropped.
module lock_ctrl #(
    parameter logic [15:0] PASSWORD      = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES = 250_000_000,
    parameter int unsigned ERR_CYCLES    = 100_000_000,
    parameter int unsigned ALARM_CYCLES  = 500_000_000,
    parameter int unsigned MAX_TRY       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] status,
    output logic       alarm,
    output logic [2:0] digit_cnt
);

    localparam int unsigned MAX_AB  = (UNLOCK_CYCLES > ERR_CYCLES) ? UNLOCK_CYCLES : ERR_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > ALARM_CYCLES) ? MAX_AB : ALARM_CYCLES;
    localparam int unsigned TMR_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] ERR_LAST   = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0] ALARM_LAST = TMR_W'(ALARM_CYCLES - 1);
    localparam logic [2:0]       MAX_FAIL   = 3'(MAX_TRY);

    // State encoding equals the status code shown on the LEDs.
    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      buf_q, buf_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       fail_q, fail_d;
    logic             alarm_q, alarm_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic       is_digit, is_clear, is_enter;
    logic       open_done, err_done;
    logic [2:0] fail_next;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clear  = key_valid && (key_code == 4'd10);
    assign is_enter  = key_valid && (key_code == 4'd11);
    assign open_done = (tmr_q == OPEN_LAST);
    assign err_done  = (tmr_q == (alarm_q ? ALARM_LAST : ERR_LAST));
    // Fail count saturates so a misconfigured MAX_TRY cannot wrap it.
    assign fail_next = (fail_q == MAX_FAIL) ? fail_q : fail_q + 3'd1;

    // Register all controller state; reset aborts any OPEN/ERROR hold at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOCKED;
            buf_q   <= 16'h0;
            cnt_q   <= 3'd0;
            fail_q  <= 3'd0;
            alarm_q <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            alarm_q <= alarm_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state logic: key handling in LOCKED, timed holds in OPEN/ERROR (timer expiry beats a coincident key).
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        alarm_d = alarm_q;
        tmr_d   = '0;
        case (state_q)
            ST_LOCKED: begin
                if (is_digit) begin
                    if (cnt_q < 3'd4) begin
                        buf_d = {buf_q[11:0], key_code};
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (is_clear) begin
                    buf_d = 16'h0;
                    cnt_d = 3'd0;
                end else if (is_enter) begin
                    buf_d = 16'h0;
                    cnt_d = 3'd0;
                    if ((cnt_q == 3'd4) && (buf_q == PASSWORD)) begin
                        state_d = ST_OPEN;
                        fail_d  = 3'd0;
                    end else begin
                        state_d = ST_ERROR;
                        fail_d  = fail_next;
                        alarm_d = (fail_next == MAX_FAIL);
                    end
                end
            end
            ST_OPEN: begin
                if (open_done || is_enter) begin
                    state_d = ST_LOCKED;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_ERROR: begin
                if (err_done) begin
                    state_d = ST_LOCKED;
                    if (alarm_q) begin
                        alarm_d = 1'b0;
                        fail_d  = 3'd0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    assign status    = state_q;
    assign alarm     = alarm_q;
    assign digit_cnt = cnt_q;

endmodule
